// File: rtl/recorder_sample_scheduler_if.sv
// Handshake bundle between sensor requesters, the sample scheduler and the recorder write port.
interface recorder_sample_scheduler_if #(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 24
);
  logic                            enable;
  logic [NUM_CH-1:0]               req_valid;
  logic [NUM_CH*PAYLOAD_WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]               req_ready;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_ready;
  logic                            busy;

  modport master (
    output enable, req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, busy
  );

  modport slave (
    input  enable, req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/recorder_sample_scheduler.sv
// Round-robin scheduler sharing the recorder write port between NUM_CH sensor requesters.
// Optional macro PRIO_CH0_EN gives channel 0 strict priority over the round-robin group.
module recorder_sample_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  recorder_sample_scheduler_if.slave bus
);
  localparam int CH_W     = $clog2(NUM_CH);
  localparam int TS_WIDTH = DATA_WIDTH - PAYLOAD_WIDTH - CH_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_out_valid;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic [CH_W-1:0]          r_rr_ptr;
  logic [TS_WIDTH-1:0]      r_ts;

  logic                     w_slot_free;
  logic                     w_grant_ok;
  logic                     w_xfer;
  logic                     w_upd_ptr;
  logic [CH_W:0]            w_pick;
  logic [CH_W-1:0]          w_win;
  logic [NUM_CH-1:0]        w_req_ready;
  logic [PAYLOAD_WIDTH-1:0] w_payload;

  // Returns {found, index} of the first set bit at or above ptr, wrapping.
  function automatic logic [CH_W:0] f_rr_pick(input logic [NUM_CH-1:0] valid,
                                              input logic [CH_W-1:0]   ptr);
    logic            found;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + CH_W'(k);
      if (!found && valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  // Winner selection and one-hot grant; a grant needs RUN, enable and a free output slot
  always_comb begin
    w_slot_free = !r_out_valid || bus.out_ready;
    w_grant_ok  = (r_state == ST_RUN) && bus.enable && w_slot_free;
`ifdef PRIO_CH0_EN
    if (bus.req_valid[0]) begin
      w_pick    = {1'b1, {CH_W{1'b0}}};
      w_upd_ptr = 1'b0;
    end else begin
      w_pick    = f_rr_pick({bus.req_valid[NUM_CH-1:1], 1'b0}, r_rr_ptr);
      w_upd_ptr = 1'b1;
    end
`else
    w_pick    = f_rr_pick(bus.req_valid, r_rr_ptr);
    w_upd_ptr = 1'b1;
`endif
    w_win       = w_pick[CH_W-1:0];
    w_xfer      = w_grant_ok && w_pick[CH_W];
    w_payload   = bus.req_data[int'(w_win)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    w_req_ready = '0;
    if (w_xfer) begin
      w_req_ready[w_win] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
  end

  // Mode FSM, timestamp, round-robin pointer and the one-entry output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_rr_ptr    <= '0;
      r_ts        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.enable) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_ts    <= '0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_ts <= r_ts + TS_WIDTH'(1);
          if (bus.enable) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else if (r_out_valid && !bus.out_ready) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        // Timestamp is frozen here; only a fresh IDLE->RUN restarts it
        ST_DRAIN: begin
          if (bus.enable) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else if (bus.out_ready) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= {w_win, r_ts, w_payload};
        if (w_upd_ptr) begin
          r_rr_ptr <= w_win + CH_W'(1);
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_recorder_sample_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_recorder_sample_scheduler;
  localparam int NUM_CH        = 4;
  localparam int DATA_WIDTH    = 32;
  localparam int PAYLOAD_WIDTH = 24;
  localparam int CH_W          = $clog2(NUM_CH);
  localparam int TS_WIDTH      = DATA_WIDTH - PAYLOAD_WIDTH - CH_W;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
`ifdef PRIO_CH0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  recorder_sample_scheduler_if #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
  ) bus ();

  recorder_sample_scheduler #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: recorder mode, pointer, timestamp and the pending output word
  int                    m_mode;
  int                    m_ptr;
  int                    m_ts;
  bit                    m_ov;
  logic [DATA_WIDTH-1:0] m_od;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_ptr  = 0;
    m_ts   = 0;
    m_ov   = 1'b0;
    m_od   = '0;
  endfunction

  function automatic int model_winner();
    if (m_mode != M_RUN || !bus.enable || (m_ov && !bus.out_ready)) return -1;
    if (PRIO && bus.req_valid[0]) return 0;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_ptr + k) % NUM_CH;
      if (PRIO && c == 0) continue;
      if (bus.req_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check the grant before the edge, advance the model, check outputs after it
  task automatic step(output int g);
    int                       w;
    bit                       en, ordy, prev_ov;
    logic [NUM_CH-1:0]        exp_rdy;
    logic [PAYLOAD_WIDTH-1:0] pay;
    w       = model_winner();
    exp_rdy = '0;
    pay     = '0;
    if (w >= 0) begin
      exp_rdy[w] = 1'b1;
      pay = bus.req_data[w*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    end
    #1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    en   = bus.enable;
    ordy = bus.out_ready;
    @(posedge clk);
    prev_ov = m_ov;
    if (w >= 0) begin
      m_ov = 1'b1;
      m_od = {CH_W'(w), TS_WIDTH'(m_ts), pay};
      if (!(PRIO && w == 0)) m_ptr = (w + 1) % NUM_CH;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    case (m_mode)
      M_IDLE:  if (en) begin m_mode = M_RUN; m_ts = 0; end
      M_RUN: begin
        m_ts = (m_ts + 1) % (1 << TS_WIDTH);
        if (!en) m_mode = (prev_ov && !ordy) ? M_DRAIN : M_IDLE;
      end
      M_DRAIN: if (en) m_mode = M_RUN; else if (ordy) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    #1;
    check("out_valid", 64'(bus.out_valid), 64'(m_ov));
    check("out_data",  64'(bus.out_data),  64'(m_od));
    check("busy",      64'(bus.busy),      64'(m_mode != M_IDLE));
    g = w;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic fill_payloads();
    for (int c = 0; c < NUM_CH; c++)
      bus.req_data[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = PAYLOAD_WIDTH'($urandom);
  endtask

  initial begin
    int g;
    bus.enable    = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    model_reset();
    pulse_reset();

    // All channels requesting with a free sink: rotation and timestamps 0..5
    bus.enable    = 1'b1;
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    fill_payloads();
    step(g);
    for (int i = 0; i < 6; i++) begin
      step(g);
      check("seq_ch", 64'(bus.out_data[DATA_WIDTH-1 -: CH_W]), PRIO ? 64'd0 : 64'(i % NUM_CH));
      check("seq_ts", 64'(bus.out_data[PAYLOAD_WIDTH +: TS_WIDTH]), 64'(i));
    end

    // Single channel 2 request right after enable
    pulse_reset();
    bus.enable    = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_data[2*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = 24'hABCDEF;
    bus.out_ready = 1'b1;
    step(g);
    step(g);
    check("ch2_word", 64'(bus.out_data), 64'h80ABCDEF);

    // Backpressure for five cycles, then release grants in the same cycle
    bus.req_valid = '1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(g);
      check("bp_hold", 64'(bus.out_data), 64'h80ABCDEF);
    end
    bus.out_ready = 1'b1;
    step(g);
    check("bp_regrant", 64'(g >= 0), 64'd1);

    // enable falls with a stalled word: DRAIN until the sink accepts
    bus.enable    = 1'b0;
    bus.out_ready = 1'b0;
    step(g);
    check("drain_busy", 64'(bus.busy), 64'd1);
    step(g);
    bus.out_ready = 1'b1;
    step(g);
    check("drain_done_valid", 64'(bus.out_valid), 64'd0);
    check("drain_done_busy",  64'(bus.busy),      64'd0);

    // Reset mid-operation with a pending word and a moved pointer
    bus.enable    = 1'b1;
    bus.req_valid = '1;
    fill_payloads();
    for (int i = 0; i < 4; i++) step(g);
    pulse_reset();
    step(g);
    step(g);
    check("post_rst_ch", 64'(bus.out_data[DATA_WIDTH-1 -: CH_W]), 64'd0);
    check("post_rst_ts", 64'(bus.out_data[PAYLOAD_WIDTH +: TS_WIDTH]), 64'd0);

    // Channel 0 continuously requesting, then withdrawn
    for (int i = 0; i < 4; i++) begin
      step(g);
`ifdef PRIO_CH0_EN
      check("prio_ch0", 64'(g), 64'd0);
`endif
    end
    bus.req_valid = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      step(g);
`ifdef PRIO_CH0_EN
      check("prio_rr", 64'(g), 64'((i % 3) + 1));
`endif
    end

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (i == 400) pulse_reset();
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.req_valid = NUM_CH'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      fill_payloads();
      step(g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/recorder_sample_scheduler.md
Name: recorder_sample_scheduler

Overview:
- Shares the single recorder write port (sensor_din path) between NUM_CH independent sensor requesters.
- Per-channel valid/ready handshake; round-robin arbitration; one granted sample per cycle.
- Each granted payload is packed with channel ID and a free-running timestamp into one DATA_WIDTH word.
- Output is a one-entry registered stage with valid/ready toward the recorder write side.

Parameters:
- NUM_CH, 4, number of sensor requesters (power of 2, 2..8).
- DATA_WIDTH, 32, packed output word width.
- PAYLOAD_WIDTH, 24, per-channel sample payload width.
- CH_W, $clog2(NUM_CH), channel ID field width (derived).
- TS_WIDTH, DATA_WIDTH-PAYLOAD_WIDTH-CH_W, timestamp field width (derived, must be >=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  recorder is in RECORDING; gates new grants
- req_valid  in  NUM_CH  per-channel sample valid
- req_data  in  NUM_CH*PAYLOAD_WIDTH  channel i payload at [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
- req_ready  out  NUM_CH  one-hot grant/accept, combinational
- out_valid  out  1  packed word valid
- out_data  out  DATA_WIDTH  {ch_id[CH_W], timestamp[TS_WIDTH], payload[PAYLOAD_WIDTH]}, ch_id in MSBs
- out_ready  in  1  downstream accepts word
- busy  out  1  state != IDLE

Behaviour:
- Reset: out_valid=0, out_data=0, req_ready=0, busy=0, rr_ptr=0, timestamp=0, state=IDLE.
- States:
  - IDLE: enable=0, no pending word.
  - RUN: enable=1.
  - DRAIN: enable fell while out_valid=1.
- Transitions:
  - IDLE->RUN on enable=1.
  - RUN->IDLE on enable=0 with out_valid=0, or out_valid=1 && out_ready=1 that cycle.
  - RUN->DRAIN on enable=0 with out_valid=1 && out_ready=0.
  - DRAIN->IDLE on out_ready=1.
  - DRAIN->RUN if enable reasserts while out_valid=1.
- Timestamp:
  - Increments by 1 every clk in RUN, wraps modulo 2^TS_WIDTH.
  - Cleared to 0 on the IDLE->RUN transition.
  - Held in DRAIN.
- Slot free: out_valid=0, or out_valid=1 && out_ready=1.
- Grant: only in RUN with enable=1 and slot free.
  - Winner = first channel with req_valid set, searching from rr_ptr upward, wrapping.
  - req_ready = one-hot winner; all zero otherwise. Never asserted for a channel with req_valid=0.
- Transfer on req_valid[i] && req_ready[i]. Next cycle:
  - out_valid=1.
  - out_data={i, timestamp value sampled in the grant cycle, payload_i}.
  - rr_ptr=(i+1) mod NUM_CH.
- Latency: request to out_valid is 1 cycle. Back-to-back grants give full throughput when out_ready stays high.
- Backpressure: while out_valid && !out_ready, out_data is held stable, no grant, rr_ptr unchanged.
- No word pending and no grant: out_valid deasserts on the next clk after acceptance; out_data keeps its last value.
- enable falling: no new grant that cycle; a pending word is still delivered (DRAIN). Words are never dropped.
- All req_valid low: no grant, rr_ptr unchanged.
- Fairness: each continuously requesting channel is granted at least once every NUM_CH grants.
- Reset asserted mid-operation: everything returns to reset values immediately; any pending word is discarded.

Optional Feature:
- Macro: PRIO_CH0_EN.
- Defined: channel 0 has strict priority. It wins whenever req_valid[0]=1 and a grant is possible, and rr_ptr is not updated by its grants. Channels 1..NUM_CH-1 round-robin among themselves when channel 0 is idle. Intended for IMU samples.
- Undefined: pure round-robin across all channels as above.

Test Plan:
- Reset then enable=1; all four req_valid=1 continuously; out_ready=1 -> grants 0,1,2,3,0,1; out_data[31:30] follows the same sequence; timestamps 0,1,2,3,4,5.
- Only ch2 valid, payload 24'hABCDEF, first grant cycle after enable -> next cycle out_valid=1, out_data=32'h80ABCDEF (ch=2, ts=0).
- out_ready=0 for 5 cycles with word pending -> out_data stable, req_ready=0 throughout; out_ready=1 -> word accepted and a new grant occurs in the same cycle.
- enable deasserted while out_valid=1 && out_ready=0 -> busy stays 1 (DRAIN), no grants; out_ready=1 -> out_valid=0 next cycle, busy=0.
- rst pulsed while out_valid=1 and rr_ptr=3 -> outputs zero immediately; after release, first grant with all channels valid goes to ch0 with ts=0.
- PRIO_CH0_EN defined, all channels valid -> ch0 granted every cycle; drop req_valid[0] -> grants 1,2,3,1.
